// File: rtl/input_buffer_if.sv
// Link and route-computation side signals of one router input port.
// Master drives incoming flits and stall; slave is the input buffer.
interface input_buffer_if #(
    parameter int W = 32
);
    logic         flit_valid_in;
    logic [W-1:0] flit_in;
    logic         vc_in;
    logic         stall;
    logic [W-1:0] flit_out;
    logic         flit_valid_out;
    logic [2:0]   dir_out;
    logic         credit_valid;
    logic         credit_vc;
    logic         overflow_err;

    modport master (
        output flit_valid_in, flit_in, vc_in, stall,
        input  flit_out, flit_valid_out, dir_out,
        input  credit_valid, credit_vc, overflow_err
    );

    modport slave (
        input  flit_valid_in, flit_in, vc_in, stall,
        output flit_out, flit_valid_out, dir_out,
        output credit_valid, credit_vc, overflow_err
    );
endinterface

// File: rtl/input_buffer.sv
// Torus router input unit: two VC FIFOs with wormhole arbitration,
// first-word fall-through output and per-flit credit return.
package para;
    localparam int FLIT_SIZE  = 32;
    localparam int HEADER_LEN = 2;

    typedef enum logic [1:0] {
        HEAD_FLIT   = 2'b00,
        BODY_FLIT   = 2'b01,
        TAIL_FLIT   = 2'b10,
        SINGLE_FLIT = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED_0 = 2'd1,
        LOCKED_1 = 2'd2
    } arb_state_t;
endpackage

module input_buffer
    import para::*;
#(
    parameter int         FLIT_SIZE = para::FLIT_SIZE,
    parameter int         DEPTH     = 8,
    parameter logic [2:0] PORT_DIR  = 3'd0
) (
    input logic           clk,
    input logic           rst,
    input_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FLIT_SIZE-1:0] mem_q [2][DEPTH];
    logic [FLIT_SIZE-1:0] mem_d [2][DEPTH];
    logic [AW-1:0]        wr_ptr_q [2];
    logic [AW-1:0]        wr_ptr_d [2];
    logic [AW-1:0]        rd_ptr_q [2];
    logic [AW-1:0]        rd_ptr_d [2];
    logic [CW-1:0]        cnt_q [2];
    logic [CW-1:0]        cnt_d [2];

    logic ovf_q, ovf_d;
    logic credit_valid_q, credit_valid_d;
    logic credit_vc_q, credit_vc_d;

    arb_state_t state_q;
    logic       rr_q;

    logic [1:0]           nonempty;
    logic                 sel_valid;
    logic                 sel_vc;
    logic                 deq;
    logic                 full;
    logic                 wr_en;
    logic [FLIT_SIZE-1:0] head;
    flit_type_t           ftype;

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            nonempty[v] = (cnt_q[v] != '0);
        end
    end

    // A locked VC is never abandoned, even while it is empty.
    always_comb begin
        sel_vc    = rr_q;
        sel_valid = 1'b0;
        unique case (state_q)
            UNLOCKED: begin
                if (nonempty[rr_q]) begin
                    sel_vc    = rr_q;
                    sel_valid = 1'b1;
                end else if (nonempty[~rr_q]) begin
                    sel_vc    = ~rr_q;
                    sel_valid = 1'b1;
                end
            end
            LOCKED_0: begin
                sel_vc    = 1'b0;
                sel_valid = nonempty[0];
            end
            LOCKED_1: begin
                sel_vc    = 1'b1;
                sel_valid = nonempty[1];
            end
            default: ;
        endcase
    end

    assign head  = mem_q[sel_vc][rd_ptr_q[sel_vc]];
    assign ftype = flit_type_t'(head[FLIT_SIZE-1 -: HEADER_LEN]);
    assign deq   = sel_valid & ~bus.stall;

    // Fullness is judged before this cycle's dequeue.
    assign full  = (cnt_q[bus.vc_in] == CW'(DEPTH));
    assign wr_en = bus.flit_valid_in & ~full;

    always_comb begin
        logic wr;
        logic rd;
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[bus.vc_in][wr_ptr_q[bus.vc_in]] = bus.flit_in;
        end
        for (int v = 0; v < 2; v++) begin
            wr          = wr_en & (bus.vc_in == 1'(v));
            rd          = deq & (sel_vc == 1'(v));
            wr_ptr_d[v] = wr ? wr_ptr_q[v] + AW'(1) : wr_ptr_q[v];
            rd_ptr_d[v] = rd ? rd_ptr_q[v] + AW'(1) : rd_ptr_q[v];
            unique case ({wr, rd})
                2'b10:   cnt_d[v] = cnt_q[v] + CW'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - CW'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
    end

    always_comb begin
        ovf_d          = ovf_q | (bus.flit_valid_in & full);
        credit_valid_d = deq;
        credit_vc_d    = deq ? sel_vc : credit_vc_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            ovf_q          <= 1'b0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
        end
    end

    // Stray body/tail flits while unlocked pass through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            rr_q    <= 1'b0;
        end else if (deq) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (ftype == HEAD_FLIT) begin
                        state_q <= sel_vc ? LOCKED_1 : LOCKED_0;
                    end else if (ftype == SINGLE_FLIT) begin
                        rr_q <= ~sel_vc;
                    end
                end
                LOCKED_0, LOCKED_1: begin
                    if (ftype == TAIL_FLIT) begin
                        state_q <= UNLOCKED;
                        rr_q    <= ~sel_vc;
                    end
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

    assign bus.flit_out       = head;
    assign bus.flit_valid_out = sel_valid;
    assign bus.dir_out        = PORT_DIR;
    assign bus.credit_valid   = credit_valid_q;
    assign bus.credit_vc      = credit_vc_q;
    assign bus.overflow_err   = ovf_q;
endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: reset, FWFT latency, wormhole,
// stall hold, overflow, lock hold and mid-packet reset.
module tb_input_buffer;
    import para::*;

    localparam int         FW    = 32;
    localparam int         DEPTH = 8;
    localparam logic [2:0] PDIR  = 3'd5;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ncred;

    logic [FW-1:0] got [$];
    logic [FW-1:0] wf  [6];
    logic          wv  [6];
    logic [FW-1:0] ef  [6];

    always #5 clk = ~clk;

    input_buffer_if #(.W(FW)) bus ();

    input_buffer #(
        .FLIT_SIZE (FW),
        .DEPTH     (DEPTH),
        .PORT_DIR  (PDIR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input flit_type_t t, input int p);
        return {t, p[FW-HEADER_LEN-1:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [FW-1:0] f,
                         input logic vc);
        bus.flit_valid_in = v;
        bus.flit_in       = f;
        bus.vc_in         = vc;
    endtask

    task automatic idle;
        drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.stall = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_fvo", bus.flit_valid_out, 0);
        chk("rst_cv", bus.credit_valid, 0);
        chk("rst_cvc", bus.credit_vc, 0);
        chk("rst_ovf", bus.overflow_err, 0);
        chk("rst_dir", bus.dir_out, PDIR);
        chk("rst_st", dut.state_q, UNLOCKED);
        chk("rst_rr", dut.rr_q, 0);

        // single flit on VC0
        drive(1'b1, mk(SINGLE_FLIT, 1), 1'b0);
        tick();
        idle();
        chk("s1_fvo", bus.flit_valid_out, 1);
        chk("s1_flit", bus.flit_out, mk(SINGLE_FLIT, 1));
        chk("s1_cv_early", bus.credit_valid, 0);
        tick();
        chk("s1_cv", bus.credit_valid, 1);
        chk("s1_cvc", bus.credit_vc, 0);
        chk("s1_fvo_after", bus.flit_valid_out, 0);
        chk("s1_rr", dut.rr_q, 1);
        tick();
        chk("s1_cv_pulse", bus.credit_valid, 0);

        // interleaved packets on VC0 and VC1
        wf[0] = mk(HEAD_FLIT, 100); wv[0] = 1'b0;
        wf[1] = mk(HEAD_FLIT, 200); wv[1] = 1'b1;
        wf[2] = mk(BODY_FLIT, 101); wv[2] = 1'b0;
        wf[3] = mk(BODY_FLIT, 201); wv[3] = 1'b1;
        wf[4] = mk(TAIL_FLIT, 102); wv[4] = 1'b0;
        wf[5] = mk(TAIL_FLIT, 202); wv[5] = 1'b1;
        ef[0] = wf[0]; ef[1] = wf[2]; ef[2] = wf[4];
        ef[3] = wf[1]; ef[4] = wf[3]; ef[5] = wf[5];
        for (int i = 0; i < 12; i++) begin
            if (i < 6) drive(1'b1, wf[i], wv[i]);
            else idle();
            if (bus.flit_valid_out) got.push_back(bus.flit_out);
            tick();
        end
        idle();
        chk("ilv_n", got.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ilv%0d", i),
                (i < got.size()) ? got[i] : 'x, ef[i]);
        end
        chk("ilv_st", dut.state_q, UNLOCKED);

        // stall holds output and suppresses credits
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(SINGLE_FLIT, 10 + i), 1'b0);
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stl_fvo%0d", i), bus.flit_valid_out, 1);
            chk($sformatf("stl_flit%0d", i), bus.flit_out,
                mk(SINGLE_FLIT, 10));
            chk($sformatf("stl_cv%0d", i), bus.credit_valid, 0);
            tick();
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rel_flit%0d", i), bus.flit_out,
                mk(SINGLE_FLIT, 10 + i));
            tick();
            chk($sformatf("rel_cv%0d", i), bus.credit_valid, 1);
            chk($sformatf("rel_cvc%0d", i), bus.credit_vc, 0);
        end
        chk("rel_fvo", bus.flit_valid_out, 0);
        tick();
        chk("rel_cv_end", bus.credit_valid, 0);

        // overflow on VC1
        bus.stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, mk(SINGLE_FLIT, 20 + i), 1'b1);
            tick();
            if (i == 7) begin
                chk("ovf_at8", bus.overflow_err, 0);
                chk("cnt_at8", dut.cnt_q[1], 8);
            end
        end
        idle();
        chk("ovf_cnt", dut.cnt_q[1], 8);
        chk("ovf_set", bus.overflow_err, 1);
        bus.stall = 1'b0;
        ncred     = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive(1'b1, mk(SINGLE_FLIT, 29), 1'b1);
            else idle();
            chk($sformatf("drn%0d", i), bus.flit_out,
                mk(SINGLE_FLIT, 20 + i));
            tick();
            if (bus.credit_valid && bus.credit_vc) ncred++;
        end
        idle();
        chk("drn_fvo", bus.flit_valid_out, 0);
        chk("drn_cnt", dut.cnt_q[1], 0);
        chk("drn_cred", ncred, 8);
        chk("ovf_sticky", bus.overflow_err, 1);

        // lock holds through empty VC0
        drive(1'b1, mk(HEAD_FLIT, 30), 1'b0);
        tick();
        drive(1'b1, mk(SINGLE_FLIT, 31), 1'b1);
        chk("lk_head", bus.flit_out, mk(HEAD_FLIT, 30));
        tick();
        idle();
        chk("lk_st", dut.state_q, LOCKED_0);
        chk("lk_fvo0", bus.flit_valid_out, 0);
        tick();
        chk("lk_fvo1", bus.flit_valid_out, 0);
        drive(1'b1, mk(BODY_FLIT, 32), 1'b0);
        tick();
        drive(1'b1, mk(TAIL_FLIT, 33), 1'b0);
        chk("lk_body", bus.flit_out, mk(BODY_FLIT, 32));
        chk("lk_bvld", bus.flit_valid_out, 1);
        tick();
        idle();
        chk("lk_tail", bus.flit_out, mk(TAIL_FLIT, 33));
        tick();
        chk("lk_vc1", bus.flit_out, mk(SINGLE_FLIT, 31));
        chk("lk_vc1v", bus.flit_valid_out, 1);
        chk("lk_unl", dut.state_q, UNLOCKED);
        chk("lk_rr", dut.rr_q, 1);
        tick();
        chk("lk_empty", bus.flit_valid_out, 0);

        // reset mid-packet
        drive(1'b1, mk(HEAD_FLIT, 40), 1'b0);
        tick();
        drive(1'b1, mk(BODY_FLIT, 41), 1'b0);
        chk("mr_head", bus.flit_out, mk(HEAD_FLIT, 40));
        tick();
        idle();
        bus.stall = 1'b1;
        chk("mr_lock", dut.state_q, LOCKED_0);
        chk("mr_body", bus.flit_out, mk(BODY_FLIT, 41));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_fvo", bus.flit_valid_out, 0);
        chk("mr_st", dut.state_q, UNLOCKED);
        chk("mr_cnt0", dut.cnt_q[0], 0);
        chk("mr_cnt1", dut.cnt_q[1], 0);
        chk("mr_cv", bus.credit_valid, 0);
        chk("mr_ovf", bus.overflow_err, 0);
        chk("mr_rr", dut.rr_q, 0);
        bus.stall = 1'b0;
        drive(1'b1, mk(HEAD_FLIT, 50), 1'b1);
        tick();
        idle();
        chk("mr_new_v", bus.flit_valid_out, 1);
        chk("mr_new", bus.flit_out, mk(HEAD_FLIT, 50));
        tick();
        chk("mr_cv1", bus.credit_valid, 1);
        chk("mr_cvc1", bus.credit_vc, 1);
        chk("mr_lk1", dut.state_q, LOCKED_1);
        chk("mr_dir", bus.dir_out, PDIR);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/input_buffer.md
# input_buffer

Per-port input unit of the torus router, sitting directly upstream of route computation. Accepts flits from the incoming link into two virtual-channel FIFOs (VC class 0/1), arbitrates between VCs at packet granularity (wormhole), and presents one flit per cycle to route computation under its `stall` backpressure. Returns one credit per dequeued flit to the upstream router.

## Interface
- `FLIT_SIZE`, default from `para.sv`: flit width; type field is the top `HEADER_LEN` bits.
- `DEPTH`, default 8: flits per VC FIFO; power of two, ≥2.
- `PORT_DIR`, default 0: 3-bit direction constant of this input port, driven on `dir_out`.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `flit_valid_in` in 1: link flit valid.
- `flit_in` in FLIT_SIZE: link flit.
- `vc_in` in 1: VC the link flit belongs to, valid for every flit type.
- `stall` in 1: backpressure from route computation.
- `flit_out` out FLIT_SIZE: head flit of the selected VC.
- `flit_valid_out` out 1: `flit_out` valid.
- `dir_out` out 3: constant `PORT_DIR`, feeds route computation `dir_in`.
- `credit_valid` out 1: one-cycle credit pulse to upstream.
- `credit_vc` out 1: VC of the returned credit.
- `overflow_err` out 1: sticky, set when a write hits a full FIFO.

## Operation
- Two FIFOs, indexed by `vc_in`. Each has read/write pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, plus a count of `$clog2(DEPTH+1)` bits.
- Write: when `flit_valid_in` is high, the flit goes to FIFO[`vc_in`] if that FIFO is not full.
  - Fullness uses the pre-dequeue count.
  - A write to a full FIFO is dropped, even with a same-cycle dequeue on that VC, and sets `overflow_err` until reset.
- Read is first-word fall-through. `flit_out` is the head entry of the selected VC. `flit_valid_out` = selected VC non-empty.
- Dequeue happens on a cycle where `flit_valid_out && !stall`. At most one dequeue per cycle.
- Simultaneous write and dequeue on the same non-full VC: count unchanged, both pointers advance.
- Arbiter FSM:
  - States: `UNLOCKED`, `LOCKED_0`, `LOCKED_1`. Round-robin pointer `rr` (1 bit).
  - In `UNLOCKED`, select `rr` if FIFO[`rr`] is non-empty, else the other VC if non-empty. Otherwise no selection and `flit_valid_out`=0.
  - Dequeue of a HEAD_FLIT from VC v → `LOCKED_v`.
  - Dequeue of a SINGLE_FLIT from VC v → stay `UNLOCKED`, `rr` ← ~v.
  - Dequeue of a BODY/TAIL in `UNLOCKED` (protocol violation): forward it, no state change.
  - In `LOCKED_v`, only VC v is selectable. If FIFO[v] is empty, `flit_valid_out`=0 and there is no switch to the other VC.
  - Dequeue of a TAIL_FLIT in `LOCKED_v` → `UNLOCKED`, `rr` ← ~v.
- Credits: each dequeue of VC v produces `credit_valid`=1, `credit_vc`=v on the following cycle. No credit is issued for dropped writes.

## Timing
- Reset state:
  - Both FIFOs empty, pointers and counts 0.
  - FSM `UNLOCKED`, `rr`=0.
  - `flit_valid_out`=0, `credit_valid`=0, `credit_vc`=0, `overflow_err`=0.
  - `dir_out`=`PORT_DIR` at all times.
- A flit written at edge N into an empty selected VC is visible on `flit_out` with `flit_valid_out`=1 during cycle N+1.
- Dequeue at edge M → `credit_valid` high during cycle M+1 only.
- While `stall`=1, `flit_out`/`flit_valid_out` are held. The selection cannot change because no dequeue occurs.
- Full throughput: one flit per cycle in and out when `stall`=0.
- `rst` asserted mid-packet discards all buffered flits and the lock on the next edge. No credits are issued for discarded flits.

## Test plan
- Reset, then one SINGLE_FLIT on VC0 → `flit_valid_out`=1 one cycle after the write; with `stall`=0 it dequeues, and `credit_valid`=1, `credit_vc`=0 on the next cycle; `rr` becomes 1.
- Interleave: 3-flit packet (H,B,T) on VC0 and H,B,T on VC1 written on alternating cycles → output is VC0 H,B,T then VC1 H,B,T, never mixed.
- Hold `stall`=1 for 5 cycles with 4 flits queued → output is frozen and no credits are issued; release → 4 consecutive dequeues and 4 consecutive credit pulses.
- Write DEPTH+1=9 flits to VC1 with `stall`=1 → count=8, 9th flit dropped, `overflow_err`=1 and sticky after `stall` drops.
- In `LOCKED_0` after a head, with VC0 empty and VC1 holding a SINGLE → `flit_valid_out`=0 until VC0's body arrives; VC1 is served only after VC0's tail.
- Assert `rst` mid-packet → next cycle `flit_valid_out`=0, FSM `UNLOCKED`, counts 0; then a new HEAD on VC1 is accepted normally.
